jcnt_sched: RTL

JCNT_SCHED -- requirements
Module: jcnt_sched

---
 rtl/jcnt_sched.sv | 93 +++++++++
 1 files changed

// File: rtl/jcnt_sched.sv
// Two-requester round-robin scheduler sharing one Johnson counter; optional JCNT_SCHED_ABORT_EN.
// Latency: grant edge, then one q step per edge for len cycles, then a 1-cycle done pulse.
// Backpressure: level req, no queuing; a run is fixed once granted unless the abort feature is built in.
module jcnt_sched #(
  parameter int JW = 4,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic          busy,
  output logic [JW-1:0] q
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic          ptr;
  logic          g;
  logic [LW-1:0] rem;
  logic          pick;
  logic [LW-1:0] pick_len;
  logic [JW-1:0] q_next;

  // With both requesting, ptr names the preferred side; otherwise the lone requester wins.
  always_comb begin
    pick     = (req == 2'b11) ? ptr : req[1];
    pick_len = pick ? len1 : len0;
    q_next   = {q[JW-2:0], ~q[JW-1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= 1'b0;
      g     <= 1'b0;
      rem   <= '0;
      q     <= '0;
      gnt   <= 2'b00;
      done  <= 2'b00;
      busy  <= 1'b0;
    end else begin
      done <= 2'b00;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            g    <= pick;
            busy <= 1'b1;
            if (pick_len == '0) begin
              state <= DONE;
              done  <= {pick, ~pick};
            end else begin
              state <= RUN;
              rem   <= pick_len;
              gnt   <= {pick, ~pick};
            end
          end
        end
        RUN: begin
`ifdef JCNT_SCHED_ABORT_EN
          if (!req[g]) begin
            state <= IDLE;
            gnt   <= 2'b00;
            busy  <= 1'b0;
            rem   <= '0;
            ptr   <= ~g;
          end else
`endif
          begin
            q   <= q_next;
            rem <= rem - 1'b1;
            if (rem == LW'(1)) begin
              state <= DONE;
              gnt   <= 2'b00;
              done  <= {g, ~g};
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ptr   <= ~g;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
